// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
//
// Shared definitions for the MEM-stage data memory unit:
//   - RV32I load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state encoding for the access sequencer
//   - access legality helpers (funct3 legality and lane alignment)
// -----------------------------------------------------------------------------
package mem_pkg;

    // RV32I funct3 values for loads (all five) and stores (first three).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_MERGE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Halfwords must sit on an even byte, words on a multiple of four.
    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] lane);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_legal_load(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_legal_store(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/load_store_formatter.sv
// -----------------------------------------------------------------------------
// load_store_formatter
//
// Purely combinational lane formatting shared by the load and the
// read-modify-write store paths.
//
// Ports:
//   word        in  32  word read from the array
//   lane        in   2  byte lane (addr[1:0]) of the access
//   funct3      in   3  access size / extension
//   wdata       in  32  store data
//   load_data   out 32  selected lane, sign- or zero-extended
//   merged_word out 32  word with the addressed byte/half replaced by wdata
// -----------------------------------------------------------------------------
module load_store_formatter
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Little-endian: lane n holds bits [8n+7:8n]; a halfword at lane 2
    // occupies the upper 16 bits.
    always_comb begin
        sel_byte = word[{lane, 3'b000} +: 8];
        sel_half = word[{lane[1], 4'b0000} +: 16];
    end

    always_comb begin
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   load_data = {24'h000000, sel_byte};
            F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
            F3_HU:   load_data = {16'h0000, sel_half};
            default: load_data = word;
        endcase
    end

    // Only SB/SH reach the merge path; a full-word store simply passes
    // wdata through so the output is well defined for every funct3.
    always_comb begin
        merged_word = word;
        case (funct3)
            F3_B:    merged_word[{lane, 3'b000} +: 8]      = wdata[7:0];
            F3_H:    merged_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged_word = wdata;
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// -----------------------------------------------------------------------------
// data_memory_unit
//
// MEM-stage load/store responder for the 5-stage RV32I pipeline. Owns a
// 2^ADDR_WIDTH x 32 synchronous-read/synchronous-write word array and
// serves byte, halfword and word accesses. Sub-word stores are done as a
// read-modify-write because the array has no byte enables.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   memread  in   1  load request
//   memwrite in   1  store request (wins over memread when both are high)
//   funct3   in   3  RV32I load/store funct3
//   addr     in  32  byte address; bits above ADDR_WIDTH+1 alias
//   wdata    in  32  store data
//   rdata    out 32  registered, formatted load result (held between loads)
//   stall    out  1  combinational pipeline freeze
//   fault    out  1  sticky misaligned / illegal-funct3 flag, cleared by rst
//
// Access timing:
//   LW/LH/LB/LHU/LBU : IDLE (read issued) -> LOAD (format, capture) -> DONE
//   SB/SH            : IDLE (read issued) -> MERGE (write back)     -> DONE
//   SW               : written in the IDLE cycle, no stall
//   faulting request : no array access, no stall, fault set
// -----------------------------------------------------------------------------
module data_memory_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        fault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0] mem_array [DEPTH];
    logic [31:0] rd_word;

    // ------------------------------------------------------------------
    // Sequencer state and the request captured at acceptance
    // ------------------------------------------------------------------
    state_t                state;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [1:0]            lane_q;
    logic [2:0]            f3_q;
    logic [31:0]           wdata_q;

    // ------------------------------------------------------------------
    // Request decode (meaningful only in IDLE)
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic                  is_store;
    logic                  is_load;
    logic                  bad_req;
    logic                  req_sw;
    logic                  req_sub;
    logic                  req_ld;

    // High address bits only alias; they are intentionally not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    always_comb begin
        idx      = addr[ADDR_WIDTH+1:2];
        lane     = addr[1:0];
        is_store = memwrite;
        // A simultaneous read+write request is a store.
        is_load  = memread & ~memwrite;
        bad_req  = (is_store & (~is_legal_store(funct3) | is_misaligned(funct3, lane))) |
                   (is_load  & (~is_legal_load(funct3)  | is_misaligned(funct3, lane)));
        req_sw   = is_store & ~bad_req & (funct3 == F3_W);
        req_sub  = is_store & ~bad_req & (funct3 != F3_W);
        req_ld   = is_load  & ~bad_req;
    end

    // ------------------------------------------------------------------
    // Formatter, fed from the registered read word and captured request
    // ------------------------------------------------------------------
    logic [31:0] load_data;
    logic [31:0] merged_word;

    load_store_formatter u_formatter (
        .word        (rd_word),
        .lane        (lane_q),
        .funct3      (f3_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // ------------------------------------------------------------------
    // Stall: pure function of state and the live request
    // ------------------------------------------------------------------
    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE:  stall = req_ld | req_sub;
            ST_LOAD:  stall = 1'b1;
            ST_MERGE: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Array port control
    // ------------------------------------------------------------------
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [31:0]           mem_wword;

    always_comb begin
        // Writes are blocked during reset so an interrupted read-modify-write
        // never lands a partial store.
        mem_we    = ~rst & (((state == ST_IDLE) & req_sw) | (state == ST_MERGE));
        mem_re    = (state == ST_IDLE) & (req_ld | req_sub);
        mem_waddr = (state == ST_MERGE) ? idx_q : idx;
        mem_wword = (state == ST_MERGE) ? merged_word : wdata;
    end

    // Single-port style inferred RAM: synchronous write and registered read.
    // Reads and writes never target the array in the same cycle because
    // reads are only issued from IDLE and merges write back from MERGE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[mem_waddr] <= mem_wword;
        end
        if (mem_re) begin
            rd_word <= mem_array[idx];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered rdata / fault
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rdata   <= 32'h0000_0000;
            fault   <= 1'b0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            f3_q    <= 3'b000;
            wdata_q <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bad_req) begin
                        fault <= 1'b1;
                    end
                    if (req_ld | req_sub) begin
                        idx_q   <= idx;
                        lane_q  <= lane;
                        f3_q    <= funct3;
                        wdata_q <= wdata;
                    end
                    if (req_ld) begin
                        state <= ST_LOAD;
                    end else if (req_sub) begin
                        state <= ST_MERGE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    rdata <= load_data;
                    state <= ST_DONE;
                end
                ST_MERGE: begin
                    state <= ST_DONE;
                end
                default: begin
                    // DONE: the pipeline advances on this edge; inputs ignored.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_data_memory_unit
//
// Drives directed and randomized load/store transactions into
// data_memory_unit and compares stall, rdata and fault every cycle against
// a transaction-level model of the memory (a plain word array) plus a few
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_data_memory_unit;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    // ---------------------------------------------------------------
    // Clock / reset / DUT
    // ---------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic        memread;
    logic        memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;

    always #5 clk = ~clk;

    data_memory_unit #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .memread  (memread),
        .memwrite (memwrite),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .fault    (fault)
    );

    // ---------------------------------------------------------------
    // Model state and bookkeeping
    // ---------------------------------------------------------------
    logic [31:0] model_mem [DEPTH];
    logic        exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("rdata", rdata, exp_rdata);
            check("fault", {31'b0, fault}, {31'b0, exp_fault});
        end
    end

    // ---------------------------------------------------------------
    // Model helpers
    // ---------------------------------------------------------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] w,
                                               input int lane,
                                               input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> (8 * lane);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_value(input logic [31:0] w,
                                                input int lane,
                                                input logic [2:0] f3,
                                                input logic [31:0] wd);
        logic [31:0] mask;
        mask = (size_of(f3) == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << (8 * lane);
        return (w & ~mask) | ((wd << (8 * lane)) & mask);
    endfunction

    // ---------------------------------------------------------------
    // Driver
    // ---------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        memread  = 1'b0;
        memwrite = 1'b0;
        funct3   = 3'b000;
        addr     = 32'h0;
        wdata    = 32'h0;
    endtask

    // Runs one request from the IDLE cycle until the unit is idle again,
    // keeping exp_* in step. Called #1 after a rising edge.
    task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd);
        int  idx;
        int  lane;
        bit  is_st;
        bit  is_ld;
        bit  legal;
        bit  misal;
        int  sz;
        idx   = int'((a >> 2) % DEPTH);
        lane  = int'(a % 4);
        is_st = wr;
        is_ld = rd && !wr;
        legal = is_st ? (f3 inside {3'b000, 3'b001, 3'b010})
                      : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        sz    = size_of(f3);
        misal = ((sz == 2) && (lane % 2 != 0)) || ((sz == 4) && (lane != 0));

        memread  = rd;
        memwrite = wr;
        funct3   = f3;
        addr     = a;
        wdata    = wd;

        if (!is_st && !is_ld) begin
            exp_stall = 1'b0;
            cycle();
        end else if (!legal || misal) begin
            exp_stall = 1'b0;
            cycle();
            exp_fault = 1'b1;
        end else if (is_st && sz == 4) begin
            exp_stall = 1'b0;
            cycle();
            model_mem[idx] = wd;
        end else begin
            exp_stall = 1'b1;
            cycle();
            cycle();
            if (is_ld) exp_rdata = load_value(model_mem[idx], lane, f3);
            else       model_mem[idx] = merge_value(model_mem[idx], lane, f3, wd);
            exp_stall = 1'b0;
            // The unit must ignore whatever is presented in its final cycle.
            memread  = 1'($urandom_range(0, 1));
            memwrite = 1'($urandom_range(0, 1));
            funct3   = 3'($urandom_range(0, 7));
            addr     = $urandom;
            wdata    = $urandom;
            cycle();
        end
        idle_inputs();
        exp_stall = 1'b0;
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    logic [2:0]  legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bit          r_rd;
    bit          r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    int          r_lane;

    initial begin
        rst = 1'b1;
        idle_inputs();
        exp_stall = 1'b0;
        exp_rdata = 32'h0;
        exp_fault = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state pinned by literals.
        check("reset_rdata", rdata, 32'h0);
        check("reset_fault", {31'b0, fault}, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'h0);

        // Give every word the random phase touches a known value.
        for (int i = 0; i < 16; i++) op(0, 1, 3'b010, i * 4, $urandom);

        // SW then LW of the same word.
        op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        op(1, 0, 3'b010, 32'h10, 32'h0);
        check("lw_deadbeef", rdata, 32'hDEADBEEF);

        // SB over a zero word, then byte loads.
        op(0, 1, 3'b010, 32'h10, 32'h0);
        op(0, 1, 3'b000, 32'h11, 32'h0000_0080);
        op(1, 0, 3'b010, 32'h10, 32'h0);
        check("sb_merged_word", rdata, 32'h0000_8000);
        op(1, 0, 3'b000, 32'h11, 32'h0);
        check("lb_sign", rdata, 32'hFFFF_FF80);
        op(1, 0, 3'b100, 32'h11, 32'h0);
        check("lbu_zero", rdata, 32'h0000_0080);

        // SH into the upper half of a patterned word.
        op(0, 1, 3'b010, 32'h20, 32'hAAAA_AAAA);
        op(0, 1, 3'b001, 32'h22, 32'h0000_1234);
        op(1, 0, 3'b001, 32'h22, 32'h0);
        check("lh_upper", rdata, 32'h0000_1234);
        op(1, 0, 3'b010, 32'h20, 32'h0);
        check("sh_merged_word", rdata, 32'h1234_AAAA);

        // memread+memwrite together behaves as a store.
        op(1, 1, 3'b010, 32'h24, 32'h0BAD_F00D);
        op(1, 0, 3'b010, 32'h24, 32'h0);
        check("rw_is_store", rdata, 32'h0BAD_F00D);

        // High address bits alias onto the same word.
        op(0, 1, 3'b010, (32'd4 << AW) + 32'h8, 32'h5);
        op(1, 0, 3'b010, 32'h8, 32'h0);
        check("addr_wrap", rdata, 32'h0000_0005);
        op(0, 1, 3'b010, 32'h0, 32'h0000_0005);

        // Faulting accesses: no array change, no stall, sticky fault.
        op(1, 0, 3'b010, 32'h13, 32'h0);
        check("fault_set", {31'b0, fault}, 32'h1);
        op(0, 1, 3'b001, 32'h01, 32'hFFFF_FFFF);
        op(0, 1, 3'b100, 32'h00, 32'hFFFF_FFFF);
        op(1, 0, 3'b010, 32'h00, 32'h0);
        check("fault_no_write", rdata, 32'h0000_0005);
        check("fault_sticky", {31'b0, fault}, 32'h1);

        // Randomized traffic over words 0..15 with aliased upper bits.
        for (int n = 0; n < 400; n++) begin
            r_rd   = 1'($urandom_range(0, 1));
            r_wr   = 1'($urandom_range(0, 1));
            r_f3   = ($urandom_range(0, 7) < 6) ? legal_f3[$urandom_range(0, 4)]
                                                : 3'($urandom_range(0, 7));
            r_lane = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                if (size_of(r_f3) == 4)      r_lane = 0;
                else if (size_of(r_f3) == 2) r_lane = r_lane & 2;
            end
            r_addr = ($urandom << 12) | (32'($urandom_range(0, 15)) << 2) | 32'(r_lane);
            op(r_rd, r_wr, r_f3, r_addr, $urandom);
        end

        // Reset in the middle of a sub-word store.
        op(0, 1, 3'b010, 32'h30, 32'h1122_3344);
        memread  = 1'b0;
        memwrite = 1'b1;
        funct3   = 3'b000;
        addr     = 32'h31;
        wdata    = 32'h0000_00AB;
        exp_stall = 1'b1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle_inputs();
        exp_stall = 1'b0;
        exp_rdata = 32'h0;
        exp_fault = 1'b0;
        check("rst_rdata", rdata, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        cycle();
        op(1, 0, 3'b010, 32'h30, 32'h0);
        check("rst_no_partial_store", rdata, 32'h1122_3344);

        cycle();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
